// File: rtl/rat_timer_counter_pkg.sv
// Shared RAT I/O definitions: port IDs, control-register bit positions,
// timer FSM state type and the prescaler divide helper.
package rat_io_pkg;

  localparam logic [7:0] TC_LO_ID  = 8'hB0;
  localparam logic [7:0] TC_MID_ID = 8'hB1;
  localparam logic [7:0] TC_HI_ID  = 8'hB2;
  localparam logic [7:0] CTRL_ID   = 8'hB5;
  localparam logic [7:0] STAT_ID   = 8'hB6;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_PSC_LO  = 2;
  localparam int CTRL_PSC_HI  = 3;
  localparam int CTRL_CLR     = 7;

  localparam logic [3:0] INT_CYCLES_DEF = 4'd4;

  typedef enum logic {TC_IDLE, TC_RUN} tc_state_t;

  // Terminal value of the 6-bit prescaler for a divide of 1/4/16/64.
  function automatic logic [5:0] psc_limit(input logic [1:0] psc);
    case (psc)
      2'd0:    psc_limit = 6'd0;
      2'd1:    psc_limit = 6'd3;
      2'd2:    psc_limit = 6'd15;
      default: psc_limit = 6'd63;
    endcase
  endfunction

endpackage

// File: rtl/rat_timer_counter_if.sv
// RAT MCU I/O bus as seen by one peripheral: port write strobe/data,
// the status byte returned to the input mux and the interrupt request.
interface rat_timer_counter_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic       TC_INT;
  logic [7:0] STAT_DATA;

  modport master (output PORT_ID, output OUT_PORT, output IO_STRB,
                  input  TC_INT,  input  STAT_DATA);
  modport slave  (input  PORT_ID, input  OUT_PORT, input  IO_STRB,
                  output TC_INT,  output STAT_DATA);
endinterface

// File: rtl/rat_timer_counter_int_stretch.sv
// rat_int_stretch: turns a one-clock trigger into an interrupt that is
// high for WIDTH clocks starting one clock after the trigger edge.
// A trigger while a pulse is still counting reloads it and flags overrun.
module rat_int_stretch #(
  parameter logic [3:0] WIDTH = 4'd4
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic irq,
  output logic overrun
);

  logic [3:0] pulse_cnt;

  assign overrun = trig && (pulse_cnt != 4'd0);

  // Pulse length counter: load on trigger, otherwise count down to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pulse_cnt <= 4'd0;
    else if (trig)
      pulse_cnt <= WIDTH;
    else if (pulse_cnt != 4'd0)
      pulse_cnt <= pulse_cnt - 4'd1;
  end

  // Registered output gives the one-clock trigger-to-rise delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      irq <= 1'b0;
    else
      irq <= (pulse_cnt != 4'd0);
  end

endmodule

// File: rtl/rat_timer_counter.sv
// rat_timer_counter: 24-bit interval timer on the RAT I/O bus.
// Optional feature macro RAT_TC_PRESCALER_EN adds a 1/4/16/64 prescaler
// selected by ctrl[3:2]; without it every clock is a tick and PSC reads 0.
//
// state   | meaning
// TC_IDLE | stopped: EN=0 or tc=0, cnt held at 0
// TC_RUN  | counting ticks toward tc-1
module rat_timer_counter
  import rat_io_pkg::*;
#(
  parameter logic [3:0] INT_CYCLES = INT_CYCLES_DEF
) (
  input logic               CLK,
  input logic               RESET,
  rat_timer_counter_if.slave bus
);

  logic [15:0] tc_stage;
  logic [23:0] tc;
  logic [23:0] cnt;
  logic        en;
  logic        oneshot;
  logic        pend;
  logic        ovr;
  logic        tick;
  logic        count_en;
  logic        evt;
  logic        oneshot_stop;
  logic        overrun;
  tc_state_t   state, state_nxt;

  logic wr_lo, wr_mid, wr_hi, wr_ctrl, clr_wr;

  assign wr_lo   = bus.IO_STRB && (bus.PORT_ID == TC_LO_ID);
  assign wr_mid  = bus.IO_STRB && (bus.PORT_ID == TC_MID_ID);
  assign wr_hi   = bus.IO_STRB && (bus.PORT_ID == TC_HI_ID);
  assign wr_ctrl = bus.IO_STRB && (bus.PORT_ID == CTRL_ID);
  assign clr_wr  = wr_ctrl && bus.OUT_PORT[CTRL_CLR];

`ifdef RAT_TC_PRESCALER_EN
  logic [1:0] psc;
  logic [5:0] psc_cnt;

  assign tick = (psc_cnt == psc_limit(psc));

  // Prescaler runs only while counting and restarts on every CTRL write.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      psc_cnt <= 6'd0;
    else if (wr_ctrl || !count_en || tick)
      psc_cnt <= 6'd0;
    else
      psc_cnt <= psc_cnt + 6'd1;
  end
`else
  assign tick = 1'b1;
`endif

  // Register file: tc staging/commit and the live ctrl fields.
  // CLR is a write strobe and reserved bits read 0, so only EN/ONESHOT(/PSC) are stored.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tc_stage <= 16'd0;
      tc       <= 24'd0;
      en       <= 1'b0;
      oneshot  <= 1'b0;
`ifdef RAT_TC_PRESCALER_EN
      psc      <= 2'd0;
`endif
    end else begin
      if (wr_lo)  tc_stage[7:0]  <= bus.OUT_PORT;
      if (wr_mid) tc_stage[15:8] <= bus.OUT_PORT;
      if (wr_hi)  tc             <= {bus.OUT_PORT, tc_stage};
      if (wr_ctrl) begin
        en      <= bus.OUT_PORT[CTRL_EN];
        oneshot <= bus.OUT_PORT[CTRL_ONESHOT];
`ifdef RAT_TC_PRESCALER_EN
        psc     <= bus.OUT_PORT[CTRL_PSC_HI:CTRL_PSC_LO];
`endif
      end else if (oneshot_stop) begin
        en <= 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      state <= TC_IDLE;
    else
      state <= state_nxt;
  end

  // Next state and count/event decode; the IDLE->RUN edge already counts
  // so the first event lands tc clocks after the enabling write.
  always_comb begin
    state_nxt    = state;
    count_en     = 1'b0;
    evt          = 1'b0;
    oneshot_stop = 1'b0;
    case (state)
      TC_IDLE: begin
        if (en && (tc != 24'd0)) begin
          state_nxt = TC_RUN;
          count_en  = 1'b1;
        end
      end
      TC_RUN: begin
        if (!en || (tc == 24'd0))
          state_nxt = TC_IDLE;
        else
          count_en = 1'b1;
      end
      default: state_nxt = TC_IDLE;
    endcase
    if (count_en && tick && (cnt == tc - 24'd1)) begin
      evt = 1'b1;
      if (oneshot) begin
        oneshot_stop = 1'b1;
        state_nxt    = TC_IDLE;
      end
    end
  end

  // Running count; a tc commit or CTRL write always restarts from 0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      cnt <= 24'd0;
    else if (wr_hi || wr_ctrl || evt || !count_en)
      cnt <= 24'd0;
    else if (tick)
      cnt <= cnt + 24'd1;
  end

  // Sticky flags; a new event/overrun beats a simultaneous CLR.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pend <= 1'b0;
      ovr  <= 1'b0;
    end else begin
      if (evt)         pend <= 1'b1;
      else if (clr_wr) pend <= 1'b0;
      if (overrun)     ovr  <= 1'b1;
      else if (clr_wr) ovr  <= 1'b0;
    end
  end

  rat_int_stretch #(.WIDTH(INT_CYCLES)) u_stretch (
    .clk     (CLK),
    .rst     (RESET),
    .trig    (evt),
    .irq     (bus.TC_INT),
    .overrun (overrun)
  );

  assign bus.STAT_DATA = (bus.PORT_ID == STAT_ID) ?
                         {4'b0000, ovr, pend, oneshot, (state == TC_RUN)} : 8'h00;

endmodule
